seq_det_arbiter: RTL
====================

// Module: seq_det_arbiter
// PURPOSE
//  Shares one serial "11100" sequence detector (ports clk/reset/x/y) between two bit-stream requesters.
//  Round-robin grants one frame of FRAME_LEN bits at a time.
//  Clears the detector before each frame and counts its y pulses for that frame.
//  Returns the hit count with a one-cycle done pulse to the granted requester.
//  Sits between the stream sources and the detector; the detector is otherwise unmodified.
// PARAMETERS
//  FRAME_LEN    15  bits per granted frame (>=1)
//  CNT_W        4   hit-count width; count saturates at 2**CNT_W-1
//  TIMEOUT_CYC  16  max wait for first bit after grant (used only with SEQ_ARB_TIMEOUT_EN)
// PORTS
//  clk       in   1      single clock, rising edge
//  reset     in   1      synchronous, active-high
//  req       in   2      req[i]=1: requester i wants a frame; held until done[i]
//  bit_vld   in   2      bit_vld[i]: bit_in[i] valid this cycle
//  bit_in    in   2      serial data from requester i
//  gnt       out  2      one-hot grant; high during STREAM for the winner
//  det_rst   out  1      to detector reset
//  det_x     out  1      to detector x
//  det_y     in   1      from detector y; Moore output, reflects the bit consumed at the previous edge
//  done      out  2      one-cycle pulse to requester i at frame end
//  hit_cnt   out  CNT_W  hits in the finished frame; valid while done!=0
//  err       out  1      valid with done; 1 = frame aborted
// BEHAVIOUR
//  Reset values: gnt=0, det_rst=1, det_x=0, done=0, hit_cnt=0, err=0, rr pointer=0, state=IDLE.
//  Reset mid-frame: abort silently, with no done pulse; all outputs take reset values at the next edge.
//  States:
//   IDLE: det_rst=1. Any req goes to ARB.
//   ARB (1 cycle): latch the winner w; det_rst=1; clear the bit and hit counters.
//    - Both req: w = rr pointer (0 first after reset).
//    - Otherwise the single requester wins.
//    - rr pointer <= ~w.
//   STREAM: gnt[w]=1; det_x = bit_vld[w] ? bit_in[w] : 0.
//    - det_rst stays 1 until the first accepted bit; from that cycle det_rst=0.
//    - Bits are accepted while bit_vld[w]=1, counting 1..FRAME_LEN.
//    - After the first bit, bits must be contiguous.
//    - bit_vld[w]=0 mid-frame: go to REPORT with err=1 (the detector has no enable, so a bubble corrupts it).
//    - Last (FRAME_LEN-th) bit accepted: go to DRAIN.
//   DRAIN (1 cycle): det_rst=0; det_x=0; sample det_y for the last bit.
//   REPORT (1 cycle): done[w]=1; hit_cnt and err are presented; det_rst=1; gnt=0; then IDLE.
//  Hit counting:
//   - det_y is sampled every cycle from the cycle after the first accepted bit through DRAIN inclusive.
//   - Each cycle with det_y=1 adds 1 to the count.
//   - The count saturates and never wraps.
//  Latency: grant to done = 1 (ARB) + first-bit wait + FRAME_LEN + 1 (DRAIN) + 1 cycles.
//  A req dropped during STREAM is ignored; the frame completes or aborts as normal.
//  A request from the loser stays pending and is granted next. No starvation.
// CONFIGURATION
//  SEQ_ARB_TIMEOUT_EN defined:
//   - In STREAM before the first bit, a wait counter counts cycles.
//   - At TIMEOUT_CYC cycles with no bit_vld[w], go to REPORT with err=1 and hit_cnt=0.
//   - The rr pointer still advances.
//  SEQ_ARB_TIMEOUT_EN undefined: no wait counter; STREAM waits indefinitely for the first bit.
// STRUCTURE
//  Package seq_arb_pkg: state encoding (IDLE, ARB, STREAM, DRAIN, REPORT), NUM_REQ=2, frame-length counter width.
//  Sub-module rr_arbiter2: 2-way round-robin pick with pointer register.
//   - Inputs: req, advance strobe. Output: one-hot winner.
//  The top holds the FSM, bit and hit counters, and the optional timeout counter.
// TESTING
//  1. Single stream: req=01, bits 111001110011100 contiguous -> gnt=01, done=01, hit_cnt=3, err=0.
//  2. Both req together from reset -> requester 0 served first, then 1 with no IDLE gap beyond one cycle; a third contention -> 0.
//  3. Bits 000000000000000 -> hit_cnt=0; 15 frames of 11100 with FRAME_LEN=75, CNT_W=4 -> hit_cnt=15 (saturation at 15).
//  4. Bubble: bit_vld low at bit 6 -> done pulse on next cycle path with err=1; next frame counts 3 correctly (det_rst cleared).
//  5. Reset asserted mid-STREAM -> next cycle gnt=0, det_rst=1, no done; a following req gets a full correct frame.
//  6. With SEQ_ARB_TIMEOUT_EN: grant, no bit_vld for 16 cycles -> done with err=1, hit_cnt=0; without the macro, no done after 100 cycles.

Source files
------------

// File: rtl/seq_arb_pkg.sv
// -----------------------------------------------------------------------------
// seq_arb_pkg
// Shared definitions for the "11100" detector arbiter:
//   - NUM_REQ       : number of bit-stream requesters (2)
//   - ST_*          : FSM state encoding (IDLE, ARB, STREAM, DRAIN, REPORT)
//   - frame_cnt_w() : width of the per-frame bit counter for a given FRAME_LEN
// -----------------------------------------------------------------------------
package seq_arb_pkg;

    localparam int NUM_REQ = 2;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ARB    = 3'd1;
    localparam logic [2:0] ST_STREAM = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_REPORT = 3'd4;

    // Enough bits to hold a count of 0..frame_len.
    function automatic int frame_cnt_w(input int frame_len);
        return $clog2(frame_len + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin pick. With a single requester that requester wins; with
// both, the pointer decides. On an advance strobe the pointer moves to the
// requester that did not win, so a pending loser is served next.
// Ports:
//   clk      in   1        clock, rising edge
//   reset    in   1        synchronous, active-high (pointer -> 0)
//   req      in   NUM_REQ  request vector
//   advance  in   1        commit the current winner and rotate the pointer
//   win      out  NUM_REQ  one-hot winner (zero when no request)
// -----------------------------------------------------------------------------
module rr_arbiter2
    import seq_arb_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] win
);

    logic ptr_q, ptr_d;

    always_comb begin
        win = req;
        if (&req) begin
            win = ptr_q ? 2'b10 : 2'b01;
        end
    end

    // Winner 0 hands priority to 1 and vice versa.
    always_comb begin
        ptr_d = ptr_q;
        if (advance && (|win)) begin
            ptr_d = win[0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/seq_det_arbiter.sv
// -----------------------------------------------------------------------------
// seq_det_arbiter
// Shares one serial "11100" detector between two bit-stream requesters. Each
// grant is one frame of FRAME_LEN contiguous bits; the detector is held in
// reset until the first bit, its y pulses are counted (saturating) and the
// count is returned with a one-cycle done pulse to the granted requester.
// Build option: define SEQ_ARB_TIMEOUT_EN to abort a grant whose first bit
// does not arrive within TIMEOUT_CYC cycles.
// Ports:
//   clk      in   1        clock, rising edge
//   reset    in   1        synchronous, active-high
//   req      in   2        frame request, held until done
//   bit_vld  in   2        bit_in[i] valid
//   bit_in   in   2        serial data per requester
//   gnt      out  2        one-hot grant while streaming
//   det_rst  out  1        detector reset
//   det_x    out  1        detector serial input
//   det_y    in   1        detector Moore output (previous edge's bit)
//   done     out  2        one-cycle frame-end pulse
//   hit_cnt  out  CNT_W    hits of the finished frame (valid with done)
//   err      out  1        frame aborted (valid with done)
// -----------------------------------------------------------------------------
module seq_det_arbiter
    import seq_arb_pkg::*;
#(
    parameter int FRAME_LEN   = 15,
    parameter int CNT_W       = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] bit_vld,
    input  logic [NUM_REQ-1:0] bit_in,
    output logic [NUM_REQ-1:0] gnt,
    output logic               det_rst,
    output logic               det_x,
    input  logic               det_y,
    output logic [NUM_REQ-1:0] done,
    output logic [CNT_W-1:0]   hit_cnt,
    output logic               err
);

    localparam int             BCW      = frame_cnt_w(FRAME_LEN);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(FRAME_LEN - 1);

    logic [2:0]         state_q, state_d;
    logic               w_q, w_d;
    logic [BCW-1:0]     bit_cnt_q, bit_cnt_d;
    logic               started_q, started_d;
    logic [CNT_W-1:0]   hits_q, hits_d;
    logic               err_q, err_d;
    logic               arb_adv;
    logic [NUM_REQ-1:0] arb_win;
    logic [NUM_REQ-1:0] w_onehot;
    logic               cur_vld, cur_bit;

`ifdef SEQ_ARB_TIMEOUT_EN
    localparam int            TW        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT_CYC - 1);
    logic [TW-1:0] wait_q, wait_d;
    logic          timeout;
    assign timeout = (wait_q == WAIT_LAST);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    rr_arbiter2 u_rr (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .advance (arb_adv),
        .win     (arb_win)
    );

    assign w_onehot = w_q ? 2'b10 : 2'b01;
    assign cur_vld  = bit_vld[w_q];
    assign cur_bit  = bit_in[w_q];
    assign hit_cnt  = hits_q;
    assign err      = err_q;

    always_comb begin
        state_d   = state_q;
        w_d       = w_q;
        bit_cnt_d = bit_cnt_q;
        started_d = started_q;
        hits_d    = hits_q;
        err_d     = err_q;
        arb_adv   = 1'b0;
        gnt       = '0;
        done      = '0;
        det_rst   = 1'b1;
        det_x     = 1'b0;
`ifdef SEQ_ARB_TIMEOUT_EN
        wait_d    = wait_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|req) state_d = ST_ARB;
            end
            ST_ARB: begin
                arb_adv   = 1'b1;
                w_d       = arb_win[1];
                bit_cnt_d = '0;
                started_d = 1'b0;
                hits_d    = '0;
                err_d     = 1'b0;
`ifdef SEQ_ARB_TIMEOUT_EN
                wait_d    = '0;
`endif
                state_d   = (|arb_win) ? ST_STREAM : ST_IDLE;
            end
            ST_STREAM: begin
                gnt     = w_onehot;
                det_x   = cur_vld & cur_bit;
                // Release the detector in the same cycle the first bit arrives
                // so that bit is consumed at the coming edge.
                det_rst = ~(started_q | cur_vld);
                // det_y lags one bit; it is meaningful only after a bit was taken.
                if (started_q && det_y) hits_d = sat_inc(hits_q);
                if (cur_vld) begin
                    started_d = 1'b1;
                    bit_cnt_d = bit_cnt_q + BCW'(1);
                    if (bit_cnt_q == LAST_BIT) state_d = ST_DRAIN;
                end else if (started_q) begin
                    // The detector has no enable: a gap corrupts its history.
                    err_d   = 1'b1;
                    state_d = ST_REPORT;
                end
`ifdef SEQ_ARB_TIMEOUT_EN
                else if (timeout) begin
                    err_d   = 1'b1;
                    hits_d  = '0;
                    state_d = ST_REPORT;
                end else begin
                    wait_d = wait_q + TW'(1);
                end
`endif
            end
            ST_DRAIN: begin
                // Collect the detector response to the final bit.
                det_rst = 1'b0;
                if (det_y) hits_d = sat_inc(hits_q);
                state_d = ST_REPORT;
            end
            ST_REPORT: begin
                done    = w_onehot;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            w_q       <= 1'b0;
            started_q <= 1'b0;
            hits_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            w_q       <= w_d;
            started_q <= started_d;
            hits_q    <= hits_d;
            err_q     <= err_d;
        end
    end

    // Cleared in ARB before every frame, so it needs no reset.
    always_ff @(posedge clk) begin
        bit_cnt_q <= bit_cnt_d;
    end

`ifdef SEQ_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`endif

endmodule
